// File: rtl/excess3_pkg.sv
// Shared excess-3 constants and packer state encoding, common to both the
// BCD-to-excess-3 encoder and the excess-3-to-BCD packer.
package excess3_pkg;

  localparam logic [3:0] E3_OFFSET   = 4'd3;
  localparam logic [3:0] E3_MIN      = 4'h3;
  localparam logic [3:0] E3_MAX      = 4'hC;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } pack_state_e;

endpackage

// File: rtl/excess3_digit_dec.sv
// Combinational decode of one excess-3 digit into BCD.
// Codes outside 3..C are flagged and yield the BCD_INVALID nibble.
module excess3_digit_dec
  import excess3_pkg::*;
(
  input  logic [3:0] e3_i,
  output logic [3:0] bcd_o,
  output logic       invalid_o
);

  always_comb begin
    invalid_o = (e3_i < E3_MIN) || (e3_i > E3_MAX);
    bcd_o     = invalid_o ? BCD_INVALID : (e3_i - E3_OFFSET);
  end

endmodule

// File: rtl/excess3_to_bcd_packer.sv
// Streaming excess-3 to BCD decoder that packs DIGITS digits (or fewer on
// in_last) into one word with per-digit invalid flags and a digit count.
module excess3_to_bcd_packer
  import excess3_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_e3,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic [CNT_W-1:0]      out_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

  pack_state_e          state_q, state_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic [DIGITS-1:0]    mask_q, mask_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [3:0]           dec_bcd;
  logic                 dec_invalid;

  excess3_digit_dec u_dec (
    .e3_i      (in_e3),
    .bcd_o     (dec_bcd),
    .invalid_o (dec_invalid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      bcd_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcd_d   = bcd_q;
    mask_d  = mask_q;
    count_d = count_q;

    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          // Slot selected by compare rather than a variable bit-select so the
          // index width never has to match the slot-vector address width.
          for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == CNT_W'(k)) begin
              bcd_d[4*k +: 4] = dec_bcd;
              mask_d[k]       = dec_invalid;
            end
          end
          count_d = idx_q + 1'b1;
          if ((idx_q == LAST_IDX) || in_last) begin
            state_d = HOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          idx_d   = '0;
          bcd_d   = '0;
          mask_d  = '0;
          count_d = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == HOLD);
  assign out_bcd      = bcd_q;
  assign out_err_mask = mask_q;
  assign out_count    = count_q;

endmodule

// File: tb/tb_excess3_to_bcd_packer.sv
// Directed bench for excess3_to_bcd_packer: a reference decode builds the
// expected words into a scoreboard queue that is drained as words appear.
module tb_excess3_to_bcd_packer;

  localparam int DIGITS = 4;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  typedef struct {
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   mask;
    logic [CNT_W-1:0]    count;
  } word_t;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_e3;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  out_bcd;
  logic [DIGITS-1:0]    out_err_mask;
  logic [CNT_W-1:0]     out_count;

  word_t                sb[$];
  logic [4*DIGITS-1:0]  expBcd;
  logic [DIGITS-1:0]    expMask;
  int                   expSlot;
  int                   checks;
  int                   errors;

  excess3_to_bcd_packer #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_e3        (in_e3),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_err_mask (out_err_mask),
    .out_count    (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] refDecode(input logic [3:0] code);
    if (code >= 4'd3 && code <= 4'd12) return {1'b0, code - 4'd3};
    return {1'b1, 4'hF};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearExpected();
    expBcd  = '0;
    expMask = '0;
    expSlot = 0;
  endtask

  // Drive one digit (called at a falling edge) and return at the falling
  // edge after it was accepted; the reference word is pushed on completion.
  task automatic applyStimulus(input logic [3:0] code, input logic last);
    int         n;
    logic [4:0] r;
    in_valid = 1'b1;
    in_e3    = code;
    in_last  = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    r = refDecode(code);
    expBcd[4*expSlot +: 4] = r[3:0];
    expMask[expSlot]       = r[4];
    expSlot++;
    if (last || expSlot == DIGITS) begin
      sb.push_back('{bcd: expBcd, mask: expMask, count: CNT_W'(expSlot)});
      clearExpected();
    end
  endtask

  // Wait (bounded) for a word, compare against the scoreboard head and, if
  // the consumer is ready, confirm the block clears and reopens its input.
  task automatic expectWord(input string tag);
    int    n;
    word_t e;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_bcd"},   32'(out_bcd),      32'(e.bcd));
      checkOutput({tag, "_mask"},  32'(out_err_mask), 32'(e.mask));
      checkOutput({tag, "_count"}, 32'(out_count),    32'(e.count));
    end
    if (out_ready === 1'b1) begin
      @(negedge clk);
      checkOutput({tag, "_drained"},  {31'd0, out_valid}, 32'd0);
      checkOutput({tag, "_reopened"}, {31'd0, in_ready},  32'd1);
      checkOutput({tag, "_cleared"},  32'(out_bcd),       32'd0);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_e3     = 4'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    clearExpected();

    repeat (3) @(negedge clk);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_bcd",   32'(out_bcd),       32'd0);
    checkOutput("rst_mask",  32'(out_err_mask),  32'd0);
    checkOutput("rst_count", 32'(out_count),     32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] full word");
    applyStimulus(4'h4, 1'b0);
    applyStimulus(4'h5, 1'b0);
    applyStimulus(4'hC, 1'b0);
    applyStimulus(4'h3, 1'b0);
    checkOutput("full_latency",  {31'd0, out_valid}, 32'd1);
    checkOutput("full_in_ready", {31'd0, in_ready},  32'd0);
    checkOutput("full_literal",  32'(out_bcd),       32'h0921);
    expectWord("full");

    $display("[TB] early end");
    applyStimulus(4'h7, 1'b1);
    checkOutput("early_literal", 32'(out_bcd), 32'h0004);
    expectWord("early");

    $display("[TB] invalid codes");
    applyStimulus(4'h3, 1'b0);
    applyStimulus(4'h0, 1'b0);
    applyStimulus(4'hD, 1'b0);
    applyStimulus(4'hC, 1'b0);
    checkOutput("inval_literal_bcd",  32'(out_bcd),      32'h9FF0);
    checkOutput("inval_literal_mask", 32'(out_err_mask), 32'b0110);
    expectWord("inval");

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(4'h6, 1'b0);
    applyStimulus(4'h7, 1'b0);
    applyStimulus(4'h8, 1'b0);
    applyStimulus(4'h9, 1'b1);
    in_valid = 1'b1;
    in_e3    = 4'h4;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid",    {31'd0, out_valid}, 32'd1);
      checkOutput("bp_bcd",      32'(out_bcd),       32'h6543);
      checkOutput("bp_in_ready", {31'd0, in_ready},  32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expectWord("bp");
    applyStimulus(4'h7, 1'b1);
    expectWord("bp_next");

    $display("[TB] reset mid-word");
    applyStimulus(4'h4, 1'b0);
    applyStimulus(4'h5, 1'b0);
    checkOutput("mid_partial", 32'(out_bcd), 32'h0021);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_bcd",   32'(out_bcd),      32'd0);
    checkOutput("mid_rst_count", 32'(out_count),    32'd0);
    checkOutput("mid_rst_mask",  32'(out_err_mask), 32'd0);
    #1 rst = 1'b0;
    clearExpected();
    @(negedge clk);
    applyStimulus(4'h8, 1'b0);
    applyStimulus(4'h9, 1'b0);
    applyStimulus(4'hA, 1'b0);
    applyStimulus(4'hB, 1'b0);
    checkOutput("mid_literal", 32'(out_bcd), 32'h8765);
    expectWord("mid");

    $display("[TB] reset while holding");
    out_ready = 1'b0;
    applyStimulus(4'h5, 1'b1);
    checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("hold_rst_valid", {31'd0, out_valid}, 32'd0);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    out_ready = 1'b1;
    @(negedge clk);

    $display("[TB] decode sweep");
    for (int c = 0; c < 16; c++) begin
      applyStimulus(4'(c), 1'b1);
      expectWord($sformatf("sweep_%0h", c));
    end

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/excess3_to_bcd_packer.md
Name: excess3_to_bcd_packer

Overview:
- Streaming decoder from excess-3 to BCD, the inverse direction of the team's BCD-to-excess-3 converter.
- Accepts one 4-bit excess-3 digit per handshake and converts it to BCD.
- Packs DIGITS converted digits into one word with per-digit invalid-code flags, then presents the word on a valid/ready output.
- Sits on the receive side of any path that carries excess-3 coded decimal data, e.g. display or arithmetic front ends.

Parameters:
- DIGITS, 4, number of BCD digits per output word (1..8).
- CNT_W, $clog2(DIGITS+1), width of the digit count field.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_e3 and in_last are valid this cycle.
- in_ready  output  1  block can accept a digit this cycle.
- in_e3  input  4  excess-3 coded digit.
- in_last  input  1  this digit ends the word early; the word is emitted even if fewer than DIGITS digits have arrived.
- out_valid  output  1  packed word is available.
- out_ready  input  1  consumer takes the word this cycle.
- out_bcd  output  4*DIGITS  packed BCD; digit k is in bits [4k+3:4k], first-received digit in k=0.
- out_err_mask  output  DIGITS  bit k set when digit k had an invalid excess-3 code.
- out_count  output  CNT_W  number of digits actually received in this word (1..DIGITS).

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=ACCUM, digit index=0, out_valid=0, out_bcd=0, out_err_mask=0, out_count=0. in_ready=1 once rst deasserts.
- Digit decode (combinational):
  - Valid codes are 4'h3..4'hC; bcd = e3 - 3, 4-bit.
  - Invalid codes are 0x0, 0x1, 0x2, 0xD, 0xE, 0xF; these give bcd = 4'hF and set invalid=1.
- State ACCUM:
  - in_ready=1 and out_valid=0.
  - A digit is accepted when in_valid && in_ready.
  - On acceptance: decoded nibble goes to slot idx, the invalid flag goes to out_err_mask[idx], and count = idx+1.
  - If idx==DIGITS-1 or in_last=1, go to HOLD next cycle; otherwise idx increments.
- State HOLD:
  - out_valid=1 and in_ready=0.
  - out_bcd, out_err_mask and out_count stay stable until the handshake.
  - On out_valid && out_ready: out_bcd, mask, count and idx clear to 0, state returns to ACCUM, and in_ready=1 the following cycle.
- Timing:
  - Latency: the last digit is accepted in cycle N; out_valid is high in cycle N+1.
  - Minimum spacing between words is one bubble cycle; HOLD never accepts input.
- Boundaries:
  - Unused slots in a short word (in_last early) read as 4'h0, and their mask bits are 0.
  - in_valid while in HOLD is ignored; the source must hold the digit, as standard valid/ready requires.
  - in_last on digit index DIGITS-1 is the same as a full word.
- Reset mid-word: partial digits are discarded and the next accepted digit lands in slot 0.
- Reset while in HOLD: the word is dropped and out_valid falls asynchronously.
- The block has no other state; there are no overflow conditions.

Decomposition:
- Shared package excess3_pkg holds:
  - E3_OFFSET=4'd3, E3_MIN=4'h3, E3_MAX=4'hC, BCD_INVALID=4'hF;
  - state enum {ACCUM, HOLD};
  - also used by the existing BCD-to-excess-3 side.
- Sub-module excess3_digit_dec: purely combinational 4-bit e3 -> {bcd[3:0], invalid}, instantiated once.
- Packer FSM, index counter and output registers live in excess3_to_bcd_packer.

Test Plan:
- DIGITS=4, out_ready=1; send 0x4, 0x5, 0xC, 0x3 -> out_valid one cycle after the 4th accept, out_bcd=16'h0921, out_err_mask=4'b0000, out_count=4, in_ready=0 for exactly one cycle.
- Early end: send 0x7 with in_last=1 -> out_bcd=16'h0004, out_count=1, mask=4'b0000.
- Invalid code: send 0x3, 0x0, 0xD, 0xC -> out_bcd=16'h9FF0, out_err_mask=4'b0110, out_count=4.
- Backpressure: hold out_ready=0 for 5 cycles with a full word pending -> out_valid stays 1, out_bcd unchanged, in_ready=0, extra in_valid ignored. Then out_ready=1 -> word consumed, next word starts at slot 0.
- Reset mid-word: accept 0x4, 0x5, pulse rst asynchronously between clock edges -> all outputs 0 immediately. Then send 0x8, 0x9, 0xA, 0xB -> out_bcd=16'h8765.
- Exhaustive decode sweep: all 16 codes through slot 0 with in_last=1 -> bcd=code-3 for 0x3..0xC (0x3->0, 0xC->9), and 4'hF with mask bit set otherwise.
